seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 7-segment display mux path. Watches the

---
 rtl/seg_scan_decoder.sv | 134 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers the four hex digits and dots shown on a time-multiplexed 7-segment bus.
// A digit is accepted after a stable dwell, and a frame is published once all four slots are seen.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  segments,
  input  logic [1:0]  dig_sel,
  output logic [15:0] digits,
  output logic [3:0]  dots,
  output logic [3:0]  bad,
  output logic        frame_valid
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [7:0]       seg_q, seg_p;
  logic [1:0]       sel_q, sel_p;
  logic [7:0]       stab_cnt;
  logic             captured;
  logic [3:0]       seen;
  logic             pend;
  logic [3:0][3:0]  slot_nib;
  logic [3:0]       slot_dp;
  logic [3:0]       slot_bad;

  logic             changed;
  logic [7:0]       stab_next;
  logic             capture;
  logic [7:0]       lit;
  logic [3:0]       dec_nib;
  logic             dec_bad;
  logic [3:0]       sel_oh;
  logic [3:0]       seen_next;
  logic [3:0][3:0]  slot_nib_n;
  logic [3:0]       slot_dp_n;
  logic [3:0]       slot_bad_n;

  // The sample register is compared against the one before it, which puts
  // acceptance exactly STABLE_CYCLES edges after the value reaches the ports.
  always_comb begin
    changed = ({sel_q, seg_q} != {sel_p, seg_p});
    if (changed)
      stab_next = 8'd1;
    else if (stab_cnt >= STAB_MAX)
      stab_next = STAB_MAX;
    else
      stab_next = stab_cnt + 8'd1;
    capture = !changed && !captured && (stab_next == STAB_MAX);
  end

  always_comb begin
    lit     = ACTIVE_LOW ? ~seg_q : seg_q;
    dec_bad = 1'b0;
    dec_nib = 4'h0;
    case (lit[7:1])
      7'b1111110: dec_nib = 4'h0;
      7'b0110000: dec_nib = 4'h1;
      7'b1101101: dec_nib = 4'h2;
      7'b1111001: dec_nib = 4'h3;
      7'b0110011: dec_nib = 4'h4;
      7'b1011011: dec_nib = 4'h5;
      7'b1011111: dec_nib = 4'h6;
      7'b1110000: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1111011: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b0011111: dec_nib = 4'hB;
      7'b1001110: dec_nib = 4'hC;
      7'b0111101: dec_nib = 4'hD;
      7'b1001111: dec_nib = 4'hE;
      7'b1000111: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_bad = 1'b1;
      end
    endcase
  end

  // Slot next-state includes the current capture so a same-cycle publish sees it.
  always_comb begin
    sel_oh     = 4'b0001 << sel_q;
    slot_nib_n = slot_nib;
    slot_dp_n  = slot_dp;
    slot_bad_n = slot_bad;
    if (capture) begin
      slot_nib_n[sel_q] = dec_nib;
      slot_dp_n[sel_q]  = lit[0];
      slot_bad_n[sel_q] = dec_bad;
    end
    seen_next = (pend ? 4'h0 : seen) | (capture ? sel_oh : 4'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= 8'h00;
      sel_q       <= 2'd0;
      seg_p       <= 8'h00;
      sel_p       <= 2'd0;
      stab_cnt    <= 8'd0;
      captured    <= 1'b0;
      seen        <= 4'h0;
      pend        <= 1'b0;
      slot_nib    <= '0;
      slot_dp     <= 4'h0;
      slot_bad    <= 4'h0;
      digits      <= 16'h0000;
      dots        <= 4'h0;
      bad         <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      seg_q       <= segments;
      sel_q       <= dig_sel;
      seg_p       <= seg_q;
      sel_p       <= sel_q;
      stab_cnt    <= stab_next;
      captured    <= changed ? 1'b0 : (captured | capture);
      slot_nib    <= slot_nib_n;
      slot_dp     <= slot_dp_n;
      slot_bad    <= slot_bad_n;
      seen        <= seen_next;
      pend        <= capture && (seen_next == 4'hF);
      frame_valid <= pend;
      if (pend) begin
        digits <= slot_nib_n;
        dots   <= slot_dp_n;
        bad    <= slot_bad_n;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: full scans, short dwells, illegal glyphs,
// mid-scan reset and latest-wins recapture with frame latency.
module tb_seg_scan_decoder;

  localparam int N = 4;

  // active-low port values {a..g, dp}
  localparam logic [7:0] S1     = 8'h9E;  // 1, dot lit
  localparam logic [7:0] S2     = 8'h25;  // 2, dot off
  localparam logic [7:0] S3     = 8'h0C;  // 3, dot lit
  localparam logic [7:0] SA     = 8'h11;  // A, dot off
  localparam logic [7:0] S5     = 8'h49;  // 5, dot off
  localparam logic [7:0] S8     = 8'h01;  // 8, dot off
  localparam logic [7:0] SBLANK = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  segments = SBLANK;
  logic [1:0]  dig_sel = 2'd0;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic [3:0]  bad;
  logic        frame_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  int base;
  int e_cyc;

  seg_scan_decoder #(.STABLE_CYCLES(N), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .segments(segments),
    .dig_sel(dig_sel),
    .digits(digits),
    .dots(dots),
    .bad(bad),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [1:0] s, input logic [7:0] p, input int n);
    @(negedge clk);
    dig_sel  = s;
    segments = p;
    e_cyc    = cyc + 1;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    segments = SBLANK;
    dig_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // T1: plain scan
    base = fv_cnt;
    dwell(2'd0, S1, 8);
    dwell(2'd1, S2, 8);
    dwell(2'd2, S3, 8);
    dwell(2'd3, SA, 8);
    @(negedge clk);
    chk("t1_frames", fv_cnt - base, 1);
    chk("t1_digits", digits, 16'hA321);
    chk("t1_dots", dots, 4'b0101);
    chk("t1_bad", bad, 4'b0000);

    // T2: sel 2 dwell too short, then retried
    do_reset();
    base = fv_cnt;
    dwell(2'd0, S1, 8);
    dwell(2'd1, S2, 8);
    dwell(2'd2, S3, 3);
    dwell(2'd3, SA, 8);
    dwell(2'd0, S1, 8);
    dwell(2'd1, S2, 8);
    @(negedge clk);
    chk("t2_no_frame", fv_cnt - base, 0);
    dwell(2'd2, S3, 8);
    @(negedge clk);
    chk("t2_frames", fv_cnt - base, 1);
    chk("t2_digits", digits, 16'hA321);

    // T3: blank glyph on digit 1
    do_reset();
    base = fv_cnt;
    dwell(2'd0, S1, 8);
    dwell(2'd1, SBLANK, 8);
    dwell(2'd2, S3, 8);
    dwell(2'd3, SA, 8);
    @(negedge clk);
    chk("t3_frames", fv_cnt - base, 1);
    chk("t3_digits", digits, 16'hA301);
    chk("t3_bad", bad, 4'b0010);
    chk("t3_dots", dots, 4'b0101);

    // T4: reset after three captures, outputs still hold the T3 frame
    dwell(2'd0, S1, 8);
    dwell(2'd1, S2, 8);
    dwell(2'd2, S3, 8);
    @(negedge clk);
    rst = 1'b1;
    segments = SBLANK;
    dig_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_rst_digits", digits, 16'h0000);
    chk("t4_rst_dots", dots, 4'h0);
    chk("t4_rst_bad", bad, 4'h0);
    chk("t4_rst_fv", frame_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = fv_cnt;
    dwell(2'd0, S8, 8);
    dwell(2'd1, S8, 8);
    dwell(2'd2, S8, 8);
    dwell(2'd3, S8, 8);
    @(negedge clk);
    chk("t4_frames", fv_cnt - base, 1);
    chk("t4_digits", digits, 16'h8888);
    chk("t4_dots", dots, 4'h0);

    // T5: recapture of slot 3, latest value wins; check publish latency
    do_reset();
    base = fv_cnt;
    dwell(2'd3, SA, 8);
    dwell(2'd0, S1, 8);
    dwell(2'd3, S5, 8);
    dwell(2'd1, S2, 8);
    dwell(2'd2, S3, 8);
    @(negedge clk);
    chk("t5_frames", fv_cnt - base, 1);
    chk("t5_digits", digits, 16'h5321);
    chk("t5_latency", fv_cyc - e_cyc, N + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
